uart_rx_fifo: RTL

//  Parametrised UART receiver: generalised successor to the fixed 8N1/16x receiver.

---
 rtl/uart_rx_fifo.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with parity/stop checking
// and a first-word-fall-through output FIFO.
// Ports: clk, rst (sync, active high), sample_tick (OVERSAMPLE x baud),
//  rx (async serial in); out_data/out_valid/out_ready pop handshake;
//  busy, frame_err/parity_err (1-clk pulses), overflow (sticky), fifo_count.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_tick,
    input  logic                         rx,
    output logic [DATA_BITS-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         frame_err,
    output logic                         parity_err,
    output logic                         overflow,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int FCW   = PTR_W + 1;
    localparam logic [CNT_W-1:0] MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);
    localparam logic [FCW-1:0] FULL_N = FCW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state_q, state_d;
    logic                 rx_m_q, rx_m_d;
    logic                 rx_s_q, rx_s_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 busy_q, busy_d;
    logic                 done;
    logic                 par_exp;
    logic                 push_q, push_d;
    logic [DATA_BITS-1:0] word_q, word_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_q, wr_d;
    logic [PTR_W-1:0]     rd_q, rd_d;
    logic [FCW-1:0]       count_q, count_d;
    logic [FCW-1:0]       left;
    logic [DATA_BITS-1:0] head_q, head_d;
    logic                 ovf_q, ovf_d;
    logic                 full, pop, wr_en;

    assign rx_m_d  = rx;
    assign rx_s_d  = rx_m_q;
    assign par_exp = (PARITY == 2) ? ~^shift_q : ^shift_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        busy_d  = busy_q;
        done    = 1'b0;
        if (sample_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == MID) begin
                        cnt_d = '0;
                        if (rx_s_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            bit_d   = '0;
                            busy_d  = 1'b1;
                            ferr_d  = 1'b0;
                            perr_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 4'd1;
                        if (bit_q == LAST_DATA) begin
                            bit_d   = '0;
                            state_d = (PARITY != 0) ? PAR : STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PAR: begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        perr_d  = (rx_s_q != par_exp);
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
                        if (!rx_s_q) ferr_d = 1'b1;
                        if (bit_q == LAST_STOP) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done    = 1'b1;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // Flags use this frame's final error state, including the last stop sample.
        push_d       = done && !ferr_d && !perr_d;
        frame_err_d  = done && ferr_d;
        parity_err_d = done && perr_d;
        word_d       = done ? shift_q : word_q;
    end

    always_comb begin
        full    = (count_q == FULL_N);
        pop     = (count_q != '0) && out_ready;
        wr_en   = push_q && (!full || pop);
        ovf_d   = ovf_q | (push_q && full && !pop);
        wr_d    = wr_en ? wr_q + PTR_W'(1) : wr_q;
        rd_d    = pop ? rd_q + PTR_W'(1) : rd_q;
        count_d = count_q;
        if (wr_en && !pop) count_d = count_q + FCW'(1);
        else if (!wr_en && pop) count_d = count_q - FCW'(1);
        // Head after this cycle: next stored entry, else the word being written.
        left = count_q - {{(FCW-1){1'b0}}, pop};
        if (left == '0) head_d = wr_en ? word_q : head_q;
        else head_d = mem_q[rd_d];
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= word_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rx_m_q       <= 1'b1;
            rx_s_q       <= 1'b1;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            ferr_q       <= 1'b0;
            perr_q       <= 1'b0;
            busy_q       <= 1'b0;
            push_q       <= 1'b0;
            word_q       <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= '0;
            head_q       <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_m_q       <= rx_m_d;
            rx_s_q       <= rx_s_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            ferr_q       <= ferr_d;
            perr_q       <= perr_d;
            busy_q       <= busy_d;
            push_q       <= push_d;
            word_q       <= word_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            count_q      <= count_d;
            head_q       <= head_d;
            ovf_q        <= ovf_d;
        end
    end

    assign out_data   = head_q;
    assign out_valid  = (count_q != '0);
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overflow   = ovf_q;
    assign fifo_count = count_q;
endmodule
